// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-ported register file and its clear engine.
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    localparam int BYTE_W = 8;

    // One byte lane of a byte-enabled write: take the new byte only when its enable is set.
    function automatic logic [BYTE_W-1:0] byte_merge(
        input logic [BYTE_W-1:0] old_val,
        input logic [BYTE_W-1:0] new_val,
        input logic              be
    );
        return be ? new_val : old_val;
    endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sequential clear engine: sweeps one register-file entry per cycle, then pulses done.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int NUM_REGISTERS = 32,
    parameter int AW            = $clog2(NUM_REGISTERS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    clr_state_e    state;
    clr_state_e    state_nxt;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Requests arriving in CLEAR or DONE fall through untouched; they are never queued.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        clr_we    = 1'b0;
        clr_busy  = 1'b0;
        clr_done  = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = '0;
                end
            end
            CLEAR: begin
                clr_we   = 1'b1;
                clr_busy = 1'b1;
                idx_nxt  = idx + AW'(1);
                if (idx == AW'(NUM_REGISTERS - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                clr_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign clr_addr = idx;

endmodule

// File: rtl/register_file_mp.sv
// Multi-ported register file: N combinational reads, M byte-enabled writes,
// optional write-to-read bypass, hardwired zero entry and a background clear sweep.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int NUM_REGISTERS   = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_READ_PORTS  = 2,
    parameter int NUM_WRITE_PORTS = 2,
    parameter int ZERO_REG        = 1,
    parameter int BYPASS          = 0,
    localparam int AW             = $clog2(NUM_REGISTERS),
    localparam int NB             = DATA_WIDTH / BYTE_W
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [NUM_READ_PORTS-1:0][AW-1:0]            A_rd,
    output logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]    RD,
    input  logic [NUM_WRITE_PORTS-1:0]                   WE,
    input  logic [NUM_WRITE_PORTS-1:0][AW-1:0]           A_wr,
    input  logic [NUM_WRITE_PORTS-1:0][DATA_WIDTH-1:0]   WD,
    input  logic [NUM_WRITE_PORTS-1:0][NB-1:0]           BE,
    input  logic                                         clr_req,
    output logic                                         clr_busy,
    output logic                                         clr_done
);

    logic [DATA_WIDTH-1:0] mem     [NUM_REGISTERS];
    logic [DATA_WIDTH-1:0] mem_nxt [NUM_REGISTERS];
    logic                  clr_we;
    logic [AW-1:0]         clr_addr;

    regfile_clr_fsm #(
        .NUM_REGISTERS (NUM_REGISTERS),
        .AW            (AW)
    ) u_clr_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Clear is applied first so any enabled external byte overrides it; ascending
    // port order lets the highest-index port win each byte it enables.
    always_comb begin
        for (int e = 0; e < NUM_REGISTERS; e++) begin
            mem_nxt[e] = mem[e];
            if (clr_we && clr_addr == AW'(e)) begin
                mem_nxt[e] = '0;
            end
            for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
                if (WE[w] && A_wr[w] == AW'(e)) begin
                    for (int b = 0; b < NB; b++) begin
                        mem_nxt[e][b*BYTE_W +: BYTE_W] = byte_merge(mem_nxt[e][b*BYTE_W +: BYTE_W],
                                                                    WD[w][b*BYTE_W +: BYTE_W],
                                                                    BE[w][b]);
                    end
                end
            end
            if (ZERO_REG != 0 && e == 0) begin
                mem_nxt[e] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < NUM_REGISTERS; e++) begin
                mem[e] <= '0;
            end
        end else begin
            for (int e = 0; e < NUM_REGISTERS; e++) begin
                mem[e] <= mem_nxt[e];
            end
        end
    end

    // Bypass overlays only external writes; the clear engine is not forwarded.
    always_comb begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            RD[p] = mem[A_rd[p]];
            if (BYPASS != 0) begin
                for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
                    if (WE[w] && A_wr[w] == A_rd[p]) begin
                        for (int b = 0; b < NB; b++) begin
                            RD[p][b*BYTE_W +: BYTE_W] = byte_merge(RD[p][b*BYTE_W +: BYTE_W],
                                                                   WD[w][b*BYTE_W +: BYTE_W],
                                                                   BE[w][b]);
                        end
                    end
                end
            end
            if (ZERO_REG != 0 && A_rd[p] == '0) begin
                RD[p] = '0;
            end
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Randomised bench for register_file_mp: two instances (no bypass / bypass) share stimulus
// and are compared every cycle against an array-based reference model.
module tb_register_file_mp;

    localparam int N = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0][4:0] a_rd;
    logic [1:0]      we;
    logic [1:0][4:0] a_wr;
    logic [1:0][31:0] wd;
    logic [1:0][3:0] be;
    logic            clr_req;

    logic [1:0][31:0] rd_a;
    logic [1:0][31:0] rd_b;
    logic            busy_a, done_a, busy_b, done_b;

    always #5 clk = ~clk;

    register_file_mp #(.BYPASS(0)) dut (
        .clk(clk), .rst_n(rst_n), .A_rd(a_rd), .RD(rd_a), .WE(we), .A_wr(a_wr),
        .WD(wd), .BE(be), .clr_req(clr_req), .clr_busy(busy_a), .clr_done(done_a)
    );

    register_file_mp #(.BYPASS(1)) dut_byp (
        .clk(clk), .rst_n(rst_n), .A_rd(a_rd), .RD(rd_b), .WE(we), .A_wr(a_wr),
        .WD(wd), .BE(be), .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b)
    );

    // Reference state: array contents plus sweep progress.
    logic [31:0] model [N];
    bit          sweep_on;
    bit          done_f;
    int          sweep_pos;

    int n_checks = 0;
    int n_errors = 0;
    int obs_busy = 0;
    int obs_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
        logic [31:0] v;
        v = model[a];
        if (byp) begin
            for (int w = 0; w < 2; w++)
                if (we[w] && a_wr[w] == a)
                    for (int b = 0; b < 4; b++)
                        if (be[w][b]) v[b*8 +: 8] = wd[w][b*8 +: 8];
        end
        if (a == 5'd0) v = 32'h0;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) model[i] = 32'h0;
        sweep_on  = 1'b0;
        done_f    = 1'b0;
        sweep_pos = 0;
    endtask

    task automatic model_edge();
        logic [31:0] nm [N];
        nm = model;
        if (sweep_on) nm[sweep_pos] = 32'h0;
        for (int w = 0; w < 2; w++)
            if (we[w])
                for (int b = 0; b < 4; b++)
                    if (be[w][b]) nm[a_wr[w]][b*8 +: 8] = wd[w][b*8 +: 8];
        nm[0] = 32'h0;
        model = nm;
        if (sweep_on) begin
            if (sweep_pos == N - 1) begin
                sweep_on = 1'b0;
                done_f   = 1'b1;
            end else begin
                sweep_pos++;
            end
        end else if (done_f) begin
            done_f = 1'b0;
        end else if (clr_req) begin
            sweep_on  = 1'b1;
            sweep_pos = 0;
        end
    endtask

    task automatic check_outputs();
        for (int p = 0; p < 2; p++) begin
            check("rd_nobyp", rd_a[p], exp_rd(1'b0, a_rd[p]));
            check("rd_byp", rd_b[p], exp_rd(1'b1, a_rd[p]));
        end
        check("busy_nobyp", {31'h0, busy_a}, {31'h0, sweep_on});
        check("done_nobyp", {31'h0, done_a}, {31'h0, done_f});
        check("busy_byp", {31'h0, busy_b}, {31'h0, sweep_on});
        check("done_byp", {31'h0, done_b}, {31'h0, done_f});
        obs_busy += int'(busy_a);
        obs_done += int'(done_a);
    endtask

    // Inputs are already set; check combinational outputs, then step one edge.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        we      = 2'b00;
        clr_req = 1'b0;
        a_rd[0] = 5'($urandom_range(0, N - 1));
        a_rd[1] = 5'($urandom_range(0, N - 1));
    endtask

    task automatic fill();
        for (int i = 0; i < N; i++) begin
            idle_inputs();
            we      = 2'b01;
            a_wr[0] = 5'(i);
            wd[0]   = $urandom;
            be[0]   = 4'hF;
            cycle();
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        a_rd    = '0;
        we      = '0;
        a_wr    = '0;
        wd      = '0;
        be      = '0;
        clr_req = 1'b0;
        model_reset();
        #2;
        check_outputs();
        check("reset_busy", {31'h0, busy_a}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Write entry i = A5A5_0000 + i, then read back on both ports.
        for (int i = 0; i < N; i++) begin
            idle_inputs();
            we      = 2'b01;
            a_wr[0] = 5'(i);
            wd[0]   = 32'hA5A5_0000 + 32'(i);
            be[0]   = 4'hF;
            cycle();
        end
        for (int i = 0; i < N; i++) begin
            idle_inputs();
            a_rd[0] = 5'(i);
            a_rd[1] = 5'(N - 1 - i);
            cycle();
            check("t1_entry", rd_a[0], (i == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(i));
        end

        // Same-cycle writes to entry 5: port 1 owns the low two bytes.
        idle_inputs();
        we      = 2'b11;
        a_wr[0] = 5'd5;  wd[0] = 32'h1111_1111;  be[0] = 4'b1111;
        a_wr[1] = 5'd5;  wd[1] = 32'h2222_2222;  be[1] = 4'b0011;
        cycle();
        idle_inputs();
        a_rd[0] = 5'd5;
        cycle();
        check("t2_entry5", rd_a[0], 32'h1111_2222);

        // Bypass: same-cycle write visible before the edge only in the bypass instance.
        idle_inputs();
        a_rd[0] = 5'd7;
        we      = 2'b01;
        a_wr[0] = 5'd7;  wd[0] = 32'hDEAD_BEEF;  be[0] = 4'hF;
        #1;
        check("t3_bypass", rd_b[0], 32'hDEAD_BEEF);
        check("t3_nobypass", rd_a[0], 32'hA5A5_0007);
        cycle();

        // Randomised traffic with colliding addresses and occasional clear requests.
        for (int k = 0; k < 400; k++) begin
            we      = 2'($urandom);
            a_wr[0] = 5'($urandom_range(0, N - 1));
            a_wr[1] = ($urandom_range(0, 3) == 0) ? a_wr[0] : 5'($urandom_range(0, N - 1));
            wd[0]   = $urandom;
            wd[1]   = $urandom;
            be[0]   = 4'($urandom);
            be[1]   = 4'($urandom);
            a_rd[0] = ($urandom_range(0, 3) == 0) ? a_wr[0] : 5'($urandom_range(0, N - 1));
            a_rd[1] = ($urandom_range(0, 3) == 0) ? a_wr[1] : 5'($urandom_range(0, N - 1));
            clr_req = ($urandom_range(0, 29) == 0);
            cycle();
        end
        for (int k = 0; k < 40; k++) begin
            idle_inputs();
            cycle();
        end

        // Full sweep with an ignored second request.
        fill();
        obs_busy = 0;
        obs_done = 0;
        idle_inputs();
        clr_req = 1'b1;
        cycle();
        for (int k = 0; k < 40; k++) begin
            idle_inputs();
            clr_req = (k == 10);
            cycle();
        end
        check("t4_busy_cycles", 32'(obs_busy), 32'd32);
        check("t4_done_pulses", 32'(obs_done), 32'd1);
        for (int i = 0; i < N; i++) begin
            idle_inputs();
            a_rd[0] = 5'(i);
            cycle();
            check("t4_cleared", rd_a[0], 32'h0);
        end

        // Writes during the sweep at idx=10 to the current and an already-swept entry.
        fill();
        obs_done = 0;
        idle_inputs();
        clr_req = 1'b1;
        cycle();
        for (int k = 0; k < 10; k++) begin
            idle_inputs();
            cycle();
        end
        idle_inputs();
        we      = 2'b11;
        a_wr[0] = 5'd10;  wd[0] = 32'h5;  be[0] = 4'hF;
        a_wr[1] = 5'd3;   wd[1] = 32'h6;  be[1] = 4'hF;
        cycle();
        for (int k = 0; k < 30; k++) begin
            idle_inputs();
            cycle();
        end
        check("t5_done_pulses", 32'(obs_done), 32'd1);
        idle_inputs();
        a_rd[0] = 5'd10;
        a_rd[1] = 5'd3;
        cycle();
        check("t5_entry10", rd_a[0], 32'h5);
        check("t5_entry3", rd_a[1], 32'h6);

        // Asynchronous reset at idx=16 aborts the sweep.
        fill();
        idle_inputs();
        clr_req = 1'b1;
        cycle();
        for (int k = 0; k < 16; k++) begin
            idle_inputs();
            cycle();
        end
        idle_inputs();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("t6_busy", {31'h0, busy_a}, 32'h0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        obs_done = 0;
        for (int k = 0; k < 40; k++) begin
            idle_inputs();
            cycle();
        end
        check("t6_no_done", 32'(obs_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
